song_player: RTL and testbench
==============================

Name: song_player

Overview:
- Read-side counterpart of the song editor.
- On start, snapshots the two 32-bit note lanes and steps through them bit by bit, index 0 upward, at a fixed tempo.
- Presents the current note of each lane, plus an 8-step look-ahead window, to the game/display logic.
- Supports pause, stop, restart and optional looping.

Parameters:
- TICKS_PER_STEP, 4, clk cycles per note step; legal range 2..65535.
- CNT_W, 16, tick counter width; must hold TICKS_PER_STEP-1.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- note1  in  32  lane-1 pattern; bit i = note at step i
- note2  in  32  lane-2 pattern
- start  in  1  single-cycle sync pulse (edge-detected upstream); begin or restart playback
- pause  in  1  single-cycle sync pulse; toggles PLAY/PAUSE
- stop  in  1  single-cycle sync pulse; abort to IDLE
- loop  in  1  level; when 1, wrap 31->0 instead of finishing
- lane1_bit  out  1  current lane-1 note
- lane2_bit  out  1  current lane-2 note
- lane1_window  out  8  lane-1 bits position..position+7 mod 32; [0] = current
- lane2_window  out  8  same for lane 2
- position  out  5  current step index
- step  out  1  one-cycle strobe when a new step is presented
- playing  out  1  high in PLAY or PAUSE
- paused  out  1  high in PAUSE
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (nrst low, asynchronous):
  - state=IDLE.
  - snap1=snap2=0, position=0, tick=0.
  - step=done=playing=paused=0.
  - All lane outputs 0.
- States: IDLE, PLAY, PAUSE, DONE. All outputs are registered.
- Command priority in a single cycle: stop > start > pause.
- stop, from any state:
  - Next cycle: state=IDLE, position=0, tick=0, playing=0, paused=0.
  - Snapshots retain their values.
- start, from any state including PLAY/PAUSE (restart):
  - Capture note1/note2 into snap1/snap2 on that edge.
  - Next cycle: state=PLAY, position=0, tick=0, step=1.
  - Later changes on note1/note2 have no effect until the next start.
- PLAY tick counting:
  - tick increments every cycle.
  - When tick==TICKS_PER_STEP-1, tick->0 and position advances; step=1 in the cycle the new position appears.
  - Step period is exactly TICKS_PER_STEP cycles.
- End of pattern (advance from position 31):
  - loop=1: position->0, step=1, stay in PLAY.
  - loop=0: state->DONE, done=1 for one cycle, step=0, position holds 31, playing=0.
  - loop is sampled at the advance edge.
- pause:
  - In PLAY -> PAUSE; in PAUSE -> PLAY.
  - tick and position are frozen in PAUSE, and resume with no lost or extra ticks.
  - pause is ignored in IDLE and DONE.
- Lane outputs:
  - lane1_bit = snap1[position], lane2_bit = snap2[position] while playing=1; otherwise 0.
  - windowN[k] = snapN[(position+k) mod 32] for k=0..7 while playing=1; otherwise 0.
  - Outputs are combinational from registered snap/position, or registered with matching alignment. Either way, they update in the same cycle that step is high.
- done is only reachable from PLAY. done and step are never high together.

Test Plan (TICKS_PER_STEP=4):
1. Basic play:
   - Stimulus: reset; note1=32'h0000_0005, note2=32'h8000_0001, loop=0; pulse start.
   - Required response: next cycle position=0, step=1, lane1_bit=1, lane2_bit=1, lane1_window=8'h05. Four cycles later position=1, lane1_bit=0, lane2_bit=0. position=31 reached 124 cycles after entering PLAY, with lane2_bit=1. Four cycles later done=1 for one cycle, state DONE, playing=0.
2. Snapshot isolation:
   - Stimulus: change note1 to 32'hFFFF_FFFF three cycles after start.
   - Required response: lane1_bit continues to follow the original 32'h0000_0005.
3. Pause:
   - Stimulus: pulse pause at tick=2 of position 5; hold 10 cycles; pulse pause again.
   - Required response: position stays 5 and paused=1 throughout. After resume, position=6 arrives exactly 2 cycles later (remaining ticks preserved).
4. Loop wrap:
   - Stimulus: loop=1; run past position 31.
   - Required response: position=0 with step=1, done stays 0. At position 30, lane1_window[2] = snap1[0] (mod-32 wrap).
5. Priority and restart:
   - Stimulus: pulse start+stop in the same cycle during PLAY.
   - Required response: IDLE, position=0, all lane outputs 0.
   - Stimulus: pulse start alone at position 17 with new note1=32'hAAAA_AAAA.
   - Required response: restart at position 0, lane1_bit=0, lane1_window=8'hAA.
6. Async reset mid-play:
   - Stimulus: drop nrst between clock edges at position 9.
   - Required response: all outputs go to reset values immediately, without waiting for a clock edge. After release, the block stays in IDLE until start.

Source files
------------

// File: rtl/song_player.sv
// Snapshots two 32-bit note lanes on start and steps through them at a fixed tempo.
// Latency: commands take effect on the next cycle; lane outputs follow position with no extra delay.
// Backpressure: none; the tempo is free-running and is frozen only while paused.
module song_player #(
    parameter int TICKS_PER_STEP = 4,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] note1,
    input  logic [31:0] note2,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    input  logic        loop,
    output logic        lane1_bit,
    output logic        lane2_bit,
    output logic [7:0]  lane1_window,
    output logic [7:0]  lane2_window,
    output logic [4:0]  position,
    output logic        step,
    output logic        playing,
    output logic        paused,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_STEP - 1);

    state_t             state;
    logic [31:0]        snap1;
    logic [31:0]        snap2;
    logic [CNT_W-1:0]   tick;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            snap1    <= '0;
            snap2    <= '0;
            tick     <= '0;
            position <= '0;
            step     <= 1'b0;
            done     <= 1'b0;
            playing  <= 1'b0;
            paused   <= 1'b0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                tick     <= '0;
                position <= '0;
                playing  <= 1'b0;
                paused   <= 1'b0;
            end else if (start) begin
                state    <= PLAY;
                snap1    <= note1;
                snap2    <= note2;
                tick     <= '0;
                position <= '0;
                step     <= 1'b1;
                playing  <= 1'b1;
                paused   <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        if (pause) begin
                            // tick is left untouched so the step resumes where it stopped
                            state  <= PAUSE;
                            paused <= 1'b1;
                        end else if (tick == TICK_LAST) begin
                            tick <= '0;
                            if (position != 5'd31) begin
                                position <= position + 5'd1;
                                step     <= 1'b1;
                            end else if (loop) begin
                                position <= '0;
                                step     <= 1'b1;
                            end else begin
                                state   <= DONE;
                                done    <= 1'b1;
                                playing <= 1'b0;
                            end
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (pause) begin
                            state  <= PLAY;
                            paused <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Window index wraps mod 32 through the 5-bit addition.
    always_comb begin
        lane1_window = '0;
        lane2_window = '0;
        for (int k = 0; k < 8; k++) begin
            lane1_window[k] = playing & snap1[position + 5'(k)];
            lane2_window[k] = playing & snap2[position + 5'(k)];
        end
    end

    assign lane1_bit = lane1_window[0];
    assign lane2_bit = lane2_window[0];

endmodule

// File: tb/tb_song_player.sv
// Directed vector table plus randomized run against a step-count reference model.
module tb_song_player;

    localparam int T = 4;
    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] note1 = '0;
    logic [31:0] note2 = '0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic        lane1_bit, lane2_bit;
    logic [7:0]  lane1_window, lane2_window;
    logic [4:0]  position;
    logic        step, playing, paused, done;

    int errors = 0;
    int checks = 0;

    song_player #(.TICKS_PER_STEP(T), .CNT_W(16)) dut (
        .clk(clk), .nrst(nrst), .note1(note1), .note2(note2),
        .start(start), .pause(pause), .stop(stop), .loop(loop),
        .lane1_bit(lane1_bit), .lane2_bit(lane2_bit),
        .lane1_window(lane1_window), .lane2_window(lane2_window),
        .position(position), .step(step), .playing(playing),
        .paused(paused), .done(done)
    );

    always #5 clk = ~clk;

    logic [26:0] act;
    assign act = {position, step, lane1_bit, lane2_bit, lane1_window, lane2_window,
                  playing, paused, done};

    function automatic logic [26:0] pk(input int pos, input bit stp, input bit l1, input bit l2,
                                       input logic [7:0] w1, input logic [7:0] w2,
                                       input bit pl, input bit pa, input bit dn);
        logic [4:0] p5;
        p5 = pos[4:0];
        return {p5, stp, l1, l2, w1, w2, pl, pa, dn};
    endfunction

    task automatic chk(input string nm, input logic [26:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got pos/step/l1/l2/w1/w2/pl/pa/dn=%h required %h (time %0t)",
                     nm, act, e, $time);
        end
    endtask

    typedef struct {
        bit          st, sp, pa, lp;
        logic [31:0] n1, n2;
        int          n;
        logic [26:0] e;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit st, input bit sp, input bit pa, input bit lp,
                       input logic [31:0] n1, input logic [31:0] n2,
                       input int n, input logic [26:0] e);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.lp = lp;
        v.n1 = n1; v.n2 = n2; v.n = n; v.e = e;
        tbl.push_back(v);
    endtask

    // Called at a negedge: drive for one cycle, run n edges, check at the following negedge.
    task automatic apply(input int id, input vec_t v);
        start = v.st; stop = v.sp; pause = v.pa; loop = v.lp;
        note1 = v.n1; note2 = v.n2;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; pause = 1'b0;
        repeat (v.n - 1) @(posedge clk);
        @(negedge clk);
        chk($sformatf("vec%0d", id), v.e);
    endtask

    // Reference model: playback is a count of elapsed play cycles; position = count / T.
    int          m_mode = M_IDLE;
    int          m_el = 0;
    logic [31:0] m_s1 = '0;
    logic [31:0] m_s2 = '0;
    bit          m_step = 0;
    bit          m_done = 0;

    task automatic model_step(input bit st, input bit sp, input bit pa, input bit lp,
                              input logic [31:0] n1, input logic [31:0] n2);
        m_step = 0;
        m_done = 0;
        if (sp) begin
            m_mode = M_IDLE;
            m_el = 0;
        end else if (st) begin
            m_s1 = n1; m_s2 = n2;
            m_mode = M_PLAY; m_el = 0; m_step = 1;
        end else if (m_mode == M_PLAY && pa) begin
            m_mode = M_PAUSE;
        end else if (m_mode == M_PAUSE && pa) begin
            m_mode = M_PLAY;
        end else if (m_mode == M_PLAY) begin
            m_el++;
            if (m_el == 32 * T) begin
                if (lp) begin
                    m_el = 0; m_step = 1;
                end else begin
                    m_mode = M_DONE; m_done = 1; m_el = 31 * T;
                end
            end else if (m_el % T == 0) begin
                m_step = 1;
            end
        end
    endtask

    function automatic logic [26:0] m_exp();
        int pos;
        bit pl;
        logic [7:0] w1, w2;
        pos = (m_mode == M_IDLE) ? 0 : (m_el / T) % 32;
        pl = (m_mode == M_PLAY) || (m_mode == M_PAUSE);
        for (int k = 0; k < 8; k++) begin
            w1[k] = pl ? m_s1[(pos + k) % 32] : 1'b0;
            w2[k] = pl ? m_s2[(pos + k) % 32] : 1'b0;
        end
        return pk(pos, m_step, w1[0], w2[0], w1, w2, pl, m_mode == M_PAUSE, m_done);
    endfunction

    initial begin
        // basic play and snapshot isolation
        add(1,0,0,0, 32'h5,         32'h8000_0001, 1,   pk(0,1,1,1,8'h05,8'h01,1,0,0));
        add(0,0,0,0, 32'h5,         32'h8000_0001, 3,   pk(0,0,1,1,8'h05,8'h01,1,0,0));
        add(0,0,0,0, 32'hFFFF_FFFF, 32'h8000_0001, 1,   pk(1,1,0,0,8'h02,8'h00,1,0,0));
        add(0,0,0,0, 32'hFFFF_FFFF, 32'h8000_0001, 3,   pk(1,0,0,0,8'h02,8'h00,1,0,0));
        add(0,0,0,0, 32'hFFFF_FFFF, 32'h8000_0001, 1,   pk(2,1,1,0,8'h01,8'h00,1,0,0));
        add(0,0,0,0, 32'h5,         32'h8000_0001, 116, pk(31,1,0,1,8'h0A,8'h03,1,0,0));
        add(0,0,0,0, 32'h5,         32'h8000_0001, 3,   pk(31,0,0,1,8'h0A,8'h03,1,0,0));
        add(0,0,0,0, 32'h5,         32'h8000_0001, 1,   pk(31,0,0,0,8'h00,8'h00,0,0,1));
        add(0,0,0,0, 32'h5,         32'h8000_0001, 1,   pk(31,0,0,0,8'h00,8'h00,0,0,0));
        add(0,0,1,0, 32'h5,         32'h8000_0001, 1,   pk(31,0,0,0,8'h00,8'h00,0,0,0));
        // pause at tick 2 of position 5
        add(1,0,0,0, 32'h5,         32'h8000_0001, 1,   pk(0,1,1,1,8'h05,8'h01,1,0,0));
        add(0,0,0,0, 32'h5,         32'h8000_0001, 22,  pk(5,0,0,0,8'h00,8'h00,1,0,0));
        add(0,0,1,0, 32'h5,         32'h8000_0001, 1,   pk(5,0,0,0,8'h00,8'h00,1,1,0));
        add(0,0,0,0, 32'h5,         32'h8000_0001, 9,   pk(5,0,0,0,8'h00,8'h00,1,1,0));
        add(0,0,1,0, 32'h5,         32'h8000_0001, 1,   pk(5,0,0,0,8'h00,8'h00,1,0,0));
        add(0,0,0,0, 32'h5,         32'h8000_0001, 1,   pk(5,0,0,0,8'h00,8'h00,1,0,0));
        add(0,0,0,0, 32'h5,         32'h8000_0001, 1,   pk(6,1,0,0,8'h00,8'h00,1,0,0));
        // stop beats start; restart mid-play
        add(1,1,0,0, 32'h5,         32'h8000_0001, 1,   pk(0,0,0,0,8'h00,8'h00,0,0,0));
        add(1,0,0,0, 32'h5,         32'h8000_0001, 1,   pk(0,1,1,1,8'h05,8'h01,1,0,0));
        add(0,0,0,0, 32'h5,         32'h8000_0001, 68,  pk(17,1,0,0,8'h00,8'h00,1,0,0));
        add(1,0,0,0, 32'hAAAA_AAAA, 32'h8000_0001, 1,   pk(0,1,0,1,8'hAA,8'h01,1,0,0));
        // looping wrap
        add(1,0,0,1, 32'h4000_0001, 32'h8000_0001, 1,   pk(0,1,1,1,8'h01,8'h01,1,0,0));
        add(0,0,0,1, 32'h4000_0001, 32'h8000_0001, 120, pk(30,1,1,0,8'h05,8'h06,1,0,0));
        add(0,0,0,1, 32'h4000_0001, 32'h8000_0001, 8,   pk(0,1,1,1,8'h01,8'h01,1,0,0));
        add(0,1,0,0, 32'h4000_0001, 32'h8000_0001, 1,   pk(0,0,0,0,8'h00,8'h00,0,0,0));
        // lead-in for async reset at position 9
        add(1,0,0,0, 32'h5,         32'h8000_0001, 1,   pk(0,1,1,1,8'h05,8'h01,1,0,0));
        add(0,0,0,0, 32'h5,         32'h8000_0001, 36,  pk(9,1,0,0,8'h00,8'h00,1,0,0));

        nrst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", 27'd0);
        nrst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 27'd0);

        foreach (tbl[i]) apply(i, tbl[i]);

        // asynchronous reset between clock edges
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("async_reset_immediate", 27'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_until_start", 27'd0);

        // randomized run; DUT and model both start from reset-state IDLE with empty snapshots
        for (int c = 0; c < 4000; c++) begin
            bit st, sp, pa, lp;
            logic [31:0] n1, n2;
            chk("random", m_exp());
            st = ($urandom_range(0, 299) == 0);
            sp = ($urandom_range(0, 499) == 0);
            pa = ($urandom_range(0, 24) == 0);
            lp = ($urandom_range(0, 199) == 0) ? ~loop : loop;
            n1 = $urandom;
            n2 = $urandom;
            if (c == 0) st = 1'b1;
            start = st; stop = sp; pause = pa; loop = lp; note1 = n1; note2 = n2;
            @(posedge clk);
            model_step(st, sp, pa, lp, n1, n2);
            #1;
            start = 1'b0; stop = 1'b0; pause = 1'b0;
            @(negedge clk);
        end
        chk("random_final", m_exp());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
